// File: rtl/pulse_burst_scheduler_if.sv
// Handshake and configuration bundle between the requesters and the pulse
// burst scheduler.
//   on         global enable; low blocks grants and aborts a running burst
//   req        per-requester request, level-sensitive
//   delay      cycles from grant to the first rising edge of signal
//   high_len   high cycles per pulse (0 behaves as 1)
//   low_len    low cycles between pulses (0 behaves as 1)
//   burst_len  pulses per burst (0 behaves as 1)
//   grant      one-hot owner of the generator
//   busy       high while a grant is held
//   signal     generated pulse train
//   done       one-cycle strobe when a burst completes normally
// The master modport is the requester side; the slave modport is the
// scheduler side.
interface pulse_burst_scheduler_if #(
  parameter int N_REQ   = 4,
  parameter int CNT_W   = 8,
  parameter int BURST_W = 4
);
  logic               on;
  logic [N_REQ-1:0]   req;
  logic [CNT_W-1:0]   delay;
  logic [CNT_W-1:0]   high_len;
  logic [CNT_W-1:0]   low_len;
  logic [BURST_W-1:0] burst_len;
  logic [N_REQ-1:0]   grant;
  logic               busy;
  logic               signal;
  logic               done;

  modport master (
    output on, req, delay, high_len, low_len, burst_len,
    input  grant, busy, signal, done
  );

  modport slave (
    input  on, req, delay, high_len, low_len, burst_len,
    output grant, busy, signal, done
  );
endinterface

// File: rtl/pulse_burst_scheduler.sv
// Shares one pulse generator between N_REQ requesters. A round-robin
// arbiter picks a winner, its timing configuration is latched at grant, and
// the block then produces a start delay followed by a burst of high/low
// pulses on signal.
//   clock    rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      scheduler side of pulse_burst_scheduler_if (on, req, config in;
//            grant, busy, signal, done out, all outputs registered)
//
// state | meaning
// IDLE  | no owner; grants the next requester while on=1
// DELAY | start delay, signal low
// HIGH  | pulse high phase
// LOW   | gap between pulses
// DONE  | one-cycle done strobe, grant still held
module pulse_burst_scheduler #(
  parameter int N_REQ   = 4,
  parameter int CNT_W   = 8,
  parameter int BURST_W = 4
) (
  input logic                   clock,
  input logic                   reset_n,
  pulse_burst_scheduler_if.slave bus
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {IDLE, DELAY, HIGH, LOW, DONE} state_t;

  state_t             state;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   win_q;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   h_q;
  logic [CNT_W-1:0]   l_q;
  logic [BURST_W-1:0] pulse_rem;

  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   req_rot;
  logic [PTR_W-1:0]   off;
  logic [PTR_W:0]     sum_raw;
  logic [PTR_W:0]     sum_wrap;
  logic [PTR_W-1:0]   win_c;
  logic [PTR_W-1:0]   win_next;
  logic [CNT_W-1:0]   h_in;
  logic [CNT_W-1:0]   l_in;
  logic [BURST_W-1:0] b_in;

  // Rotate the request vector so the pointer sits at bit 0, take the lowest
  // set bit, then rotate the offset back into an absolute index.
  always_comb begin
    req_dbl  = {bus.req, bus.req} >> ptr;
    req_rot  = req_dbl[N_REQ-1:0];
    off      = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) off = PTR_W'(i);
    end
    sum_raw  = {1'b0, ptr} + {1'b0, off};
    sum_wrap = (sum_raw >= (PTR_W+1)'(N_REQ)) ? (sum_raw - (PTR_W+1)'(N_REQ)) : sum_raw;
    win_c    = sum_wrap[PTR_W-1:0];
  end

  assign win_next = (win_q == PTR_W'(N_REQ - 1)) ? '0 : win_q + 1'b1;

  assign h_in = (bus.high_len  == '0) ? CNT_W'(1)   : bus.high_len;
  assign l_in = (bus.low_len   == '0) ? CNT_W'(1)   : bus.low_len;
  assign b_in = (bus.burst_len == '0) ? BURST_W'(1) : bus.burst_len;

  // Counters hold "cycles remaining minus one" so a phase ends when they
  // reach zero; pulse_rem counts the pulses still to follow the current one.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      ptr        <= '0;
      win_q      <= '0;
      cnt        <= '0;
      h_q        <= '0;
      l_q        <= '0;
      pulse_rem  <= '0;
      bus.grant  <= '0;
      bus.busy   <= 1'b0;
      bus.signal <= 1'b0;
      bus.done   <= 1'b0;
    end else if (state != IDLE && !bus.on) begin
      // Abort still moves the pointer past the interrupted owner.
      state      <= IDLE;
      cnt        <= '0;
      ptr        <= win_next;
      bus.grant  <= '0;
      bus.busy   <= 1'b0;
      bus.signal <= 1'b0;
      bus.done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.on && |bus.req) begin
            bus.grant <= N_REQ'(1) << win_c;
            bus.busy  <= 1'b1;
            win_q     <= win_c;
            h_q       <= h_in;
            l_q       <= l_in;
            pulse_rem <= b_in - 1'b1;
            if (bus.delay == '0) begin
              state      <= HIGH;
              bus.signal <= 1'b1;
              cnt        <= h_in - 1'b1;
            end else begin
              state <= DELAY;
              cnt   <= bus.delay - 1'b1;
            end
          end
        end
        DELAY: begin
          if (cnt == '0) begin
            state      <= HIGH;
            bus.signal <= 1'b1;
            cnt        <= h_q - 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HIGH: begin
          if (cnt == '0) begin
            bus.signal <= 1'b0;
            if (pulse_rem == '0) begin
              state    <= DONE;
              bus.done <= 1'b1;
            end else begin
              state <= LOW;
              cnt   <= l_q - 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        LOW: begin
          if (cnt == '0) begin
            state      <= HIGH;
            bus.signal <= 1'b1;
            cnt        <= h_q - 1'b1;
            pulse_rem  <= pulse_rem - 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          state     <= IDLE;
          ptr       <= win_next;
          bus.grant <= '0;
          bus.busy  <= 1'b0;
          bus.done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_burst_scheduler.sv
// Directed bench for pulse_burst_scheduler. Each stimulus step pushes the
// expected per-cycle {grant, busy, signal, done} trace onto a queue; the
// trace is popped and compared on every falling edge.
module tb_pulse_burst_scheduler;

  logic clock;
  logic reset_n;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  typedef struct packed {
    logic [3:0] grant;
    logic       busy;
    logic       signal;
    logic       done;
  } exp_t;

  exp_t q[$];

  pulse_burst_scheduler_if #(.N_REQ(4), .CNT_W(8), .BURST_W(4)) bus ();

  pulse_burst_scheduler #(.N_REQ(4), .CNT_W(8), .BURST_W(4)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  function automatic exp_t observed();
    exp_t o;
    o = {bus.grant, bus.busy, bus.signal, bus.done};
    return o;
  endfunction

  task automatic check(input string tag, input exp_t obs, input exp_t exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed g=%b b=%b s=%b d=%b expected g=%b b=%b s=%b d=%b",
             tag, cyc, obs.grant, obs.busy, obs.signal, obs.done,
             exp.grant, exp.busy, exp.signal, exp.done);
    end
  endtask

  task automatic push_burst(input int win, input int d, input int h, input int l, input int b);
    exp_t       e;
    logic [3:0] g;
    int he, le, be;
    g  = 4'b0001 << win;
    he = (h == 0) ? 1 : h;
    le = (l == 0) ? 1 : l;
    be = (b == 0) ? 1 : b;
    e = {g, 1'b1, 1'b0, 1'b0};
    repeat (d) q.push_back(e);
    for (int p = 1; p <= be; p++) begin
      e = {g, 1'b1, 1'b1, 1'b0};
      repeat (he) q.push_back(e);
      if (p < be) begin
        e = {g, 1'b1, 1'b0, 1'b0};
        repeat (le) q.push_back(e);
      end
    end
    e = {g, 1'b1, 1'b0, 1'b1};
    q.push_back(e);
    e = '0;
    q.push_back(e);
  endtask

  task automatic push_idle(input int n);
    exp_t e;
    e = '0;
    repeat (n) q.push_back(e);
  endtask

  // Compare up to n queued cycles (n < 0: the whole queue).
  task automatic drain(input string tag, input int n);
    exp_t e;
    int   k;
    k = 0;
    while (q.size() > 0 && (n < 0 || k < n)) begin
      @(negedge clock);
      e = q.pop_front();
      check(tag, observed(), e);
      k++;
    end
  endtask

  task automatic set_cfg(input logic [3:0] r, input int d, input int h, input int l, input int b);
    bus.req       = r;
    bus.delay     = 8'(d);
    bus.high_len  = 8'(h);
    bus.low_len   = 8'(l);
    bus.burst_len = 4'(b);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    q.delete();
    #1;
    check("reset_state", observed(), exp_t'(0));
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    reset_n = 1'b0;
    bus.on  = 1'b0;
    set_cfg(4'b0000, 0, 0, 0, 0);

    // 1: basic burst, config changed and owner swapped after grant
    do_reset();
    bus.on = 1'b1;
    set_cfg(4'b0001, 2, 3, 2, 2);
    push_burst(0, 2, 3, 2, 2);
    push_burst(2, 1, 2, 1, 3);
    drain("t1_burst", 1);
    set_cfg(4'b0100, 1, 2, 1, 3);
    drain("t1_burst", -1);
    bus.req = 4'b0000;

    // 2: all requesting, round robin with wrap
    do_reset();
    set_cfg(4'b1111, 0, 1, 0, 1);
    push_burst(0, 0, 1, 0, 1);
    push_burst(1, 0, 1, 0, 1);
    push_burst(2, 0, 1, 0, 1);
    push_burst(3, 0, 1, 0, 1);
    push_burst(0, 0, 1, 0, 1);
    drain("t2_rr", -1);
    bus.req = 4'b0000;

    // 3: all-zero config clamps to one pulse of one cycle
    do_reset();
    set_cfg(4'b0100, 0, 0, 0, 0);
    push_burst(2, 0, 0, 0, 0);
    drain("t3_zero", 1);
    bus.req = 4'b0000;
    drain("t3_zero", -1);

    // 4: on dropped in the second HIGH phase
    do_reset();
    set_cfg(4'b0001, 2, 3, 2, 2);
    push_burst(0, 2, 3, 2, 2);
    drain("t4_pre", 1);
    bus.req = 4'b0000;
    drain("t4_pre", 7);
    bus.on = 1'b0;
    q.delete();
    push_idle(3);
    drain("t4_abort", -1);
    bus.on = 1'b1;
    set_cfg(4'b0011, 1, 1, 1, 2);
    push_burst(1, 1, 1, 1, 2);
    drain("t4_regrant", 1);
    bus.req = 4'b0000;
    drain("t4_regrant", -1);

    // 5: asynchronous reset in the LOW phase
    do_reset();
    set_cfg(4'b0001, 2, 3, 2, 2);
    push_burst(0, 2, 3, 2, 2);
    drain("t5_pre", 1);
    bus.req = 4'b0000;
    drain("t5_pre", 5);
    #2;
    reset_n = 1'b0;
    #1;
    check("t5_async_reset", observed(), exp_t'(0));
    q.delete();
    @(negedge clock);
    bus.req = 4'b1010;
    reset_n = 1'b1;
    push_burst(1, 2, 3, 2, 2);
    drain("t5_after", 1);
    bus.req = 4'b0000;
    drain("t5_after", -1);

    // 6: on low blocks grants, then enabling grants req[0]
    do_reset();
    bus.on = 1'b0;
    set_cfg(4'b1111, 0, 1, 1, 1);
    push_idle(20);
    drain("t6_off", -1);
    bus.on = 1'b1;
    push_burst(0, 0, 1, 1, 1);
    drain("t6_on", 1);
    bus.req = 4'b0000;
    drain("t6_on", -1);

    // 7: maximum field values
    do_reset();
    set_cfg(4'b1000, 255, 255, 255, 15);
    push_burst(3, 255, 255, 255, 15);
    drain("t7_max", 1);
    bus.req = 4'b0000;
    drain("t7_max", -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
